// File: rtl/sine_dac_pkg.sv
// sine_dac_pkg: FSM states, unity gain constant and saturation helper for sine_dac_serializer.
package sine_dac_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam logic [15:0] GAIN_ONE = 16'h8000;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/sine_dac_fifo.sv
// sine_dac_fifo: synchronous FIFO; head word is always presented on dout from the registered array.
module sine_dac_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             din,
  input  logic                     rd_en,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_ok, rd_ok;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rp];
  // a pop on the same edge frees the slot the write lands in
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(wr_ok);
      rp <= rp + AW'(rd_ok);
      level <= level + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
endmodule

// File: rtl/sine_dac_serializer.sv
// sine_dac_serializer: optional gain (SINE_DAC_GAIN_EN), sample FIFO and MSB-first 3-wire DAC shifter.
module sine_dac_serializer
  import sine_dac_pkg::*;
#(
  parameter int MPR = 24,
  parameter int DEPTH = 4,
  parameter int CLKDIV = 4,
  parameter int GW = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic [MPR-1:0]           fsin_i,
  input  logic                     in_valid,
  input  logic [GW-1:0]            gain_i,
  output logic                     dac_sclk,
  output logic                     dac_cs_n,
  output logic                     dac_mosi,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);
  localparam int DW = $clog2(CLKDIV + 1);
  localparam int TW = $clog2(2 * MPR + 1);
  logic wr_req, full, empty, pop, tick, start;
  logic [MPR-1:0] wr_data, head, sh, sh_n;
  logic [DW-1:0] div, div_n;
  logic [TW-1:0] tog, tog_n;
  logic sclk_n, cs_n_n, mosi_n;
  state_t state, state_n;
`ifdef SINE_DAC_GAIN_EN
  localparam logic signed [MPR+GW:0] RND = (MPR+GW+1)'(1) <<< (GW - 2);
  logic signed [MPR+GW:0] prod, rnd;
  assign prod = (MPR+GW+1)'($signed(fsin_i)) * (MPR+GW+1)'($signed({1'b0, gain_i}));
  assign rnd = (prod + RND) >>> (GW - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_req <= clken && in_valid;
      wr_data <= MPR'(saturate(64'(rnd), MPR));
    end
  end
`else
  logic unused_gain;
  assign unused_gain = ^gain_i;
  assign wr_req = clken && in_valid;
  assign wr_data = fsin_i;
`endif
  sine_dac_fifo #(.W(MPR), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_req), .din(wr_data), .rd_en(pop),
    .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  assign tick = div == DW'(CLKDIV - 1);
  // a queued sample chains straight from the end of GAP so the frame period stays (2*MPR+1)*CLKDIV
  assign start = !empty && (state == IDLE || (state == GAP && tick));
  assign busy = !dac_cs_n || state == GAP;
  always_comb begin
    state_n = state;
    sclk_n = dac_sclk;
    cs_n_n = dac_cs_n;
    mosi_n = dac_mosi;
    sh_n = sh;
    div_n = div;
    tog_n = tog;
    pop = 1'b0;
    if (state == SHIFT) begin
      div_n = tick ? '0 : div + 1'b1;
      if (tick) begin
        sclk_n = !dac_sclk;
        tog_n = tog + 1'b1;
        if (dac_sclk && tog == TW'(2 * MPR - 1)) begin
          cs_n_n = 1'b1;
          mosi_n = 1'b0;
          state_n = GAP;
        end else if (dac_sclk) begin
          sh_n = sh << 1;
          mosi_n = sh[MPR-2];
        end
      end
    end else if (state == GAP) begin
      div_n = tick ? '0 : div + 1'b1;
      state_n = tick ? IDLE : GAP;
    end
    if (start) begin
      pop = 1'b1;
      sh_n = head;
      mosi_n = head[MPR-1];
      cs_n_n = 1'b0;
      div_n = '0;
      tog_n = '0;
      state_n = SHIFT;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dac_sclk <= 1'b0;
      dac_cs_n <= 1'b1;
      dac_mosi <= 1'b0;
      sh <= '0;
      div <= '0;
      tog <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      dac_sclk <= sclk_n;
      dac_cs_n <= cs_n_n;
      dac_mosi <= mosi_n;
      sh <= sh_n;
      div <= div_n;
      tog <= tog_n;
      overflow <= wr_req && full && !pop;
    end
  end
endmodule

// File: tb/tb_sine_dac_serializer.sv
// tb_sine_dac_serializer: scoreboard bench; frames are decoded from the DAC pins and matched to queued expectations.
module tb_sine_dac_serializer;
  import sine_dac_pkg::*;
  localparam int MPR = 24, DEPTH = 4, CLKDIV = 4, GW = 16;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef SINE_DAC_GAIN_EN
  localparam bit GAIN = 1'b1;
  localparam int LAT = 3;
`else
  localparam bit GAIN = 1'b0;
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, reset_n = 1'b1, clken = 1'b0, in_valid = 1'b0;
  logic [MPR-1:0] fsin_i = '0;
  logic [GW-1:0] gain_i = GAIN_ONE;
  logic dac_sclk, dac_cs_n, dac_mosi, overflow, busy;
  logic [LW-1:0] fifo_level;
  sine_dac_serializer #(.MPR(MPR), .DEPTH(DEPTH), .CLKDIV(CLKDIV), .GW(GW)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .fsin_i(fsin_i), .in_valid(in_valid),
    .gain_i(gain_i), .dac_sclk(dac_sclk), .dac_cs_n(dac_cs_n), .dac_mosi(dac_mosi),
    .overflow(overflow), .fifo_level(fifo_level), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [MPR-1:0] sb[$];
  logic [MPR-1:0] word;
  logic p_sclk = 1'b0, p_cs = 1'b1;
  int len = 0, rise = 0, frames = 0, ovf = 0, peak = 0, cyc = 0, last_fall = 0, period = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // frame decoder and pin-level monitor, sampled on the inactive clock edge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      len = 0;
      rise = 0;
    end else begin
      if (!dac_cs_n && p_cs) begin
        period = cyc - last_fall;
        last_fall = cyc;
      end
      if (!dac_cs_n) begin
        len++;
        if (dac_sclk && !p_sclk) begin
          word = {word[MPR-2:0], dac_mosi};
          rise++;
        end
      end
      if (dac_cs_n && !p_cs) begin
        if (sb.size() == 0) check("unexpected_frame", 1, 0);
        else check("frame_word", word, sb.pop_front());
        check("frame_rises", rise, MPR);
        check("frame_len", len, 2 * CLKDIV * MPR);
        frames++;
        len = 0;
        rise = 0;
      end
      if (overflow) ovf++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    p_sclk = dac_sclk;
    p_cs = dac_cs_n;
  end
  task automatic send(input logic [MPR-1:0] d, input logic [GW-1:0] g, input logic [MPR-1:0] exp, input bit drop);
    fsin_i = d;
    gain_i = g;
    clken = 1'b1;
    in_valid = 1'b1;
    if (!drop) sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && fifo_level == 0) break;
    end
    if (i == budget) check(tag, 1, 0);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_sclk"}, dac_sclk, 0);
    check({tag, "_cs_n"}, dac_cs_n, 1);
    check({tag, "_mosi"}, dac_mosi, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int bad, lat, f0;
    logic [MPR-1:0] r;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (dac_sclk || !dac_cs_n || dac_mosi || overflow || fifo_level != 0 || busy) bad++;
    end
    check("rst_hold", bad, 0);
    send(24'h800001, GAIN_ONE, 24'h800001, 1'b0);
    lat = 1;
    while (dac_cs_n && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("cs_latency", lat, LAT);
    wait_idle("single_timeout", 1000);
    send(24'sd3, 16'h4000, GAIN ? 24'd2 : 24'd3, 1'b0);
    wait_idle("gain_a_timeout", 1000);
    send(24'h7FFFFF, 16'hFFFF, 24'h7FFFFF, 1'b0);
    wait_idle("gain_b_timeout", 1000);
    send(24'h800000, 16'hFFFF, 24'h800000, 1'b0);
    wait_idle("gain_c_timeout", 1000);
    repeat (3) begin
      r = MPR'($urandom);
      send(r, GAIN_ONE, r, 1'b0);
      wait_idle("rand_timeout", 1000);
    end
    peak = 0;
    ovf = 0;
    for (int i = 0; i < 6; i++) send(MPR'(24'h100000 * (i + 1) + i), GAIN_ONE, MPR'(24'h100000 * (i + 1) + i), i == 5);
    wait_idle("ovf_timeout", 3000);
    check("ovf_peak", peak, DEPTH);
    check("ovf_pulses", ovf, 1);
    check("frame_period", period, (2 * MPR + 1) * CLKDIV);
    f0 = frames;
    clken = 1'b0;
    in_valid = 1'b1;
    fsin_i = 24'h123456;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_level != 0) bad++;
    end
    in_valid = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_level != 0 || !dac_cs_n) bad++;
    end
    check("clken_level", bad, 0);
    check("clken_frames", frames, f0);
    send(24'hA5A5A5, GAIN_ONE, 24'hA5A5A5, 1'b0);
    send(24'h5A5A5A, GAIN_ONE, 24'h5A5A5A, 1'b0);
    send(24'h0F0F0F, GAIN_ONE, 24'h0F0F0F, 1'b0);
    f0 = frames;
    lat = 0;
    while (rise < 10 && lat < 1000) begin
      @(negedge clk);
      #1 lat++;
    end
    check("mid_bit10_reached", rise, 10);
    #1 reset_n = 1'b0;
    #1 check_reset_vals("mid");
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!dac_cs_n || busy || fifo_level != 0) bad++;
    end
    check("mid_no_resume", bad, 0);
    check("mid_frames", frames, f0);
    send(24'h3C3C3C, GAIN_ONE, 24'h3C3C3C, 1'b0);
    wait_idle("post_rst_timeout", 1000);
    check("post_rst_frames", frames, f0 + 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
